// File: rtl/ucsbece154a_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ucsbece154a_pkg
// Description : Shared encodings for the multicycle RISC-V controller:
//               opcodes, funct3 values, ALU/result/immediate selects and the
//               FSM state type.
// Revision    : 1.0 - initial multicycle release
// ============================================================================
package ucsbece154a_pkg;

    // Opcodes
    localparam logic [6:0] c_OP_LW     = 7'b0000011;
    localparam logic [6:0] c_OP_SW     = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;

    // funct3 values
    localparam logic [2:0] c_F3_ADDSUB = 3'b000;
    localparam logic [2:0] c_F3_SLT    = 3'b010;
    localparam logic [2:0] c_F3_OR     = 3'b110;
    localparam logic [2:0] c_F3_AND    = 3'b111;
    localparam logic [2:0] c_F3_BEQ    = 3'b000;
    localparam logic [2:0] c_F3_BNE    = 3'b001;

    // ALUOp from the main FSM to the ALU decoder
    localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] c_ALUOP_OTHER = 2'b10;

    // ALUControl
    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_AND = 3'b010;
    localparam logic [2:0] c_ALU_OR  = 3'b011;
    localparam logic [2:0] c_ALU_SLT = 3'b101;

    // ResultSrc
    localparam logic [1:0] c_RES_ALUOUT    = 2'b00;
    localparam logic [1:0] c_RES_DATA      = 2'b01;
    localparam logic [1:0] c_RES_ALURESULT = 2'b10;
    localparam logic [1:0] c_RES_IMMEXT    = 2'b11;

    // ALU operand selects
    localparam logic [1:0] c_SRCA_PC    = 2'b00;
    localparam logic [1:0] c_SRCA_OLDPC = 2'b01;
    localparam logic [1:0] c_SRCA_RS1   = 2'b10;
    localparam logic [1:0] c_SRCB_RS2   = 2'b00;
    localparam logic [1:0] c_SRCB_IMM   = 2'b01;
    localparam logic [1:0] c_SRCB_FOUR  = 2'b10;

    // ImmSrc
    localparam logic [2:0] c_IMM_I = 3'b000;
    localparam logic [2:0] c_IMM_S = 3'b001;
    localparam logic [2:0] c_IMM_B = 3'b010;
    localparam logic [2:0] c_IMM_J = 3'b011;
    localparam logic [2:0] c_IMM_U = 3'b100;

    // FSM state encodings
    localparam logic [3:0] c_ST_FETCH    = 4'd0;
    localparam logic [3:0] c_ST_DECODE   = 4'd1;
    localparam logic [3:0] c_ST_MEMADR   = 4'd2;
    localparam logic [3:0] c_ST_MEMREAD  = 4'd3;
    localparam logic [3:0] c_ST_MEMWB    = 4'd4;
    localparam logic [3:0] c_ST_MEMWRITE = 4'd5;
    localparam logic [3:0] c_ST_EXECR    = 4'd6;
    localparam logic [3:0] c_ST_EXECI    = 4'd7;
    localparam logic [3:0] c_ST_ALUWB    = 4'd8;
    localparam logic [3:0] c_ST_BRANCH   = 4'd9;
    localparam logic [3:0] c_ST_JAL      = 4'd10;
    localparam logic [3:0] c_ST_LUI      = 4'd11;
    localparam logic [3:0] c_ST_ERROR    = 4'd12;

    typedef enum logic [3:0] {
        ST_FETCH    = c_ST_FETCH,
        ST_DECODE   = c_ST_DECODE,
        ST_MEMADR   = c_ST_MEMADR,
        ST_MEMREAD  = c_ST_MEMREAD,
        ST_MEMWB    = c_ST_MEMWB,
        ST_MEMWRITE = c_ST_MEMWRITE,
        ST_EXECR    = c_ST_EXECR,
        ST_EXECI    = c_ST_EXECI,
        ST_ALUWB    = c_ST_ALUWB,
        ST_BRANCH   = c_ST_BRANCH,
        ST_JAL      = c_ST_JAL,
        ST_LUI      = c_ST_LUI,
        ST_ERROR    = c_ST_ERROR
    } mc_state_t;

    // Immediate format selected purely by opcode; unknown opcodes fall back to I
    function automatic logic [2:0] imm_src(input logic [6:0] op);
        logic [2:0] imm;
        case (op)
            c_OP_LW, c_OP_ITYPE: imm = c_IMM_I;
            c_OP_SW:             imm = c_IMM_S;
            c_OP_BRANCH:         imm = c_IMM_B;
            c_OP_JAL:            imm = c_IMM_J;
            c_OP_LUI:            imm = c_IMM_U;
            default:             imm = c_IMM_I;
        endcase
        return imm;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ucsbece154a_aludec.sv
`default_nettype none
// ============================================================================
// Module      : ucsbece154a_aludec
// Description : Combinational ALU decoder. Turns the FSM's ALUOp plus the
//               instruction's funct3/funct7b5/op[5] into an ALUControl code.
// Revision    : 1.0 - initial multicycle release
// ============================================================================
module ucsbece154a_aludec
    import ucsbece154a_pkg::*;
(
    input  logic [1:0] i_aluop,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_op5,
    output logic [2:0] o_alu_control
);

    // Fixed add/sub for address and compare work; funct-driven for ALU ops
    always_comb begin
        o_alu_control = c_ALU_ADD;
        case (i_aluop)
            c_ALUOP_ADD: o_alu_control = c_ALU_ADD;
            c_ALUOP_SUB: o_alu_control = c_ALU_SUB;
            c_ALUOP_OTHER: begin
                case (i_funct3)
                    // only R-type (op[5]=1) may select sub; addi ignores funct7b5
                    c_F3_ADDSUB: o_alu_control = (i_funct7b5 & i_op5) ? c_ALU_SUB : c_ALU_ADD;
                    c_F3_SLT:    o_alu_control = c_ALU_SLT;
                    c_F3_OR:     o_alu_control = c_ALU_OR;
                    c_F3_AND:    o_alu_control = c_ALU_AND;
                    default:     o_alu_control = c_ALU_ADD;
                endcase
            end
            default: o_alu_control = c_ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ucsbece154a_mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : ucsbece154a_mc_controller
// Description : Multicycle RISC-V control unit. One FSM sequences each
//               instruction; a main decoder drives datapath enables/selects,
//               an ImmSrc decoder follows the opcode, and the ALU decoder
//               sub-module produces ALUControl.
// Revision    : 1.0 - initial multicycle release
// ============================================================================
module ucsbece154a_mc_controller
    import ucsbece154a_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit EXT_BRANCH    = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       Zero_i,
    input  logic       MemReady_i,
    output logic       PCWrite_o,
    output logic       AdrSrc_o,
    output logic       MemWrite_o,
    output logic       IRWrite_o,
    output logic       RegWrite_o,
    output logic [1:0] ResultSrc_o,
    output logic [1:0] ALUSrcA_o,
    output logic [1:0] ALUSrcB_o,
    output logic [2:0] ImmSrc_o,
    output logic [2:0] ALUControl_o,
    output logic       Illegal_o,
    output logic       Retire_o
);

    mc_state_t  r_state_q;
    mc_state_t  w_state_d;
    mc_state_t  w_state;
    logic       r_illegal_q;
    logic       w_illegal_d;
    logic       w_ready;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_is_bne;
    logic [1:0] w_alu_op;

    // While reset is held the outputs already look like an idle FETCH, so an
    // aborted state cannot leak a write enable into the reset cycle.
    assign w_state  = reset ? ST_FETCH : r_state_q;
    assign w_ready  = ~reset & (MEM_HANDSHAKE ? MemReady_i : 1'b1);
    assign w_is_bne = (funct3_i == c_F3_BNE);

    // Main decoder: Moore outputs per state, gated by ready where needed
    always_comb begin
        AdrSrc_o    = 1'b0;
        MemWrite_o  = 1'b0;
        IRWrite_o   = 1'b0;
        RegWrite_o  = 1'b0;
        ResultSrc_o = c_RES_ALUOUT;
        ALUSrcA_o   = c_SRCA_PC;
        ALUSrcB_o   = c_SRCB_RS2;
        w_alu_op    = c_ALUOP_ADD;
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        Retire_o    = 1'b0;
        case (w_state)
            ST_FETCH: begin
                ALUSrcB_o   = c_SRCB_FOUR;
                ResultSrc_o = c_RES_ALURESULT;
                IRWrite_o   = w_ready;
                w_pc_update = w_ready;
            end
            ST_DECODE: begin
                ALUSrcA_o = c_SRCA_OLDPC;
                ALUSrcB_o = c_SRCB_IMM;
            end
            ST_MEMADR: begin
                ALUSrcA_o = c_SRCA_RS1;
                ALUSrcB_o = c_SRCB_IMM;
            end
            ST_MEMREAD: begin
                AdrSrc_o = 1'b1;
            end
            ST_MEMWB: begin
                ResultSrc_o = c_RES_DATA;
                RegWrite_o  = 1'b1;
                Retire_o    = 1'b1;
            end
            ST_MEMWRITE: begin
                AdrSrc_o   = 1'b1;
                MemWrite_o = 1'b1;
                Retire_o   = w_ready;
            end
            ST_EXECR: begin
                ALUSrcA_o = c_SRCA_RS1;
                w_alu_op  = c_ALUOP_OTHER;
            end
            ST_EXECI: begin
                ALUSrcA_o = c_SRCA_RS1;
                ALUSrcB_o = c_SRCB_IMM;
                w_alu_op  = c_ALUOP_OTHER;
            end
            ST_ALUWB: begin
                RegWrite_o = 1'b1;
                Retire_o   = 1'b1;
            end
            ST_BRANCH: begin
                ALUSrcA_o = c_SRCA_RS1;
                w_alu_op  = c_ALUOP_SUB;
                w_branch  = 1'b1;
                Retire_o  = 1'b1;
            end
            ST_JAL: begin
                ALUSrcA_o   = c_SRCA_OLDPC;
                ALUSrcB_o   = c_SRCB_FOUR;
                w_pc_update = 1'b1;
            end
            ST_LUI: begin
                ResultSrc_o = c_RES_IMMEXT;
                RegWrite_o  = 1'b1;
                Retire_o    = 1'b1;
            end
            default: begin
                // ST_ERROR and unused encodings: everything stays quiet
            end
        endcase
    end

    // Branch resolves as taken when the compare matches the branch sense
    assign PCWrite_o = w_pc_update | (w_branch & (Zero_i ^ w_is_bne));

    assign ImmSrc_o  = imm_src(op_i);
    assign Illegal_o = r_illegal_q & ~reset;

    // Next-state logic
    always_comb begin
        w_state_d = w_state;
        case (w_state)
            ST_FETCH:    if (w_ready) w_state_d = ST_DECODE;
            ST_DECODE: begin
                case (op_i)
                    c_OP_LW, c_OP_SW: w_state_d = ST_MEMADR;
                    c_OP_RTYPE:       w_state_d = ST_EXECR;
                    c_OP_ITYPE:       w_state_d = ST_EXECI;
                    c_OP_BRANCH: begin
                        if ((funct3_i == c_F3_BEQ) || (EXT_BRANCH && w_is_bne))
                            w_state_d = ST_BRANCH;
                        else
                            w_state_d = ST_ERROR;
                    end
                    c_OP_JAL:         w_state_d = ST_JAL;
                    c_OP_LUI:         w_state_d = ST_LUI;
                    default:          w_state_d = ST_ERROR;
                endcase
            end
            ST_MEMADR:   w_state_d = (op_i == c_OP_SW) ? ST_MEMWRITE : ST_MEMREAD;
            ST_MEMREAD:  if (w_ready) w_state_d = ST_MEMWB;
            ST_MEMWB:    w_state_d = ST_FETCH;
            ST_MEMWRITE: if (w_ready) w_state_d = ST_FETCH;
            ST_EXECR:    w_state_d = ST_ALUWB;
            ST_EXECI:    w_state_d = ST_ALUWB;
            ST_ALUWB:    w_state_d = ST_FETCH;
            ST_BRANCH:   w_state_d = ST_FETCH;
            ST_JAL:      w_state_d = ST_ALUWB;
            ST_LUI:      w_state_d = ST_FETCH;
            ST_ERROR:    w_state_d = ST_ERROR;
            default:     w_state_d = ST_ERROR;
        endcase
    end

    // Illegal flag sets on the edge that enters ERROR and holds until reset
    assign w_illegal_d = r_illegal_q | (w_state_d == ST_ERROR);

    // State and sticky-flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q   <= ST_FETCH;
            r_illegal_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_illegal_q <= w_illegal_d;
        end
    end

    // ALU decoder
    ucsbece154a_aludec u_aludec (
        .i_aluop       (w_alu_op),
        .i_funct3      (funct3_i),
        .i_funct7b5    (funct7b5_i),
        .i_op5         (op_i[5]),
        .o_alu_control (ALUControl_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_ucsbece154a_mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_ucsbece154a_mc_controller
// Description : Self-checking bench. Each instruction is expanded into the
//               per-cycle output vectors it must produce; every cycle is
//               compared, and hand-computed literals pin key points.
// Revision    : 1.0 - initial multicycle release
// ============================================================================
module tb_ucsbece154a_mc_controller;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    typedef struct packed {
        logic       pcw, adr, memw, irw, regw;
        logic [1:0] res, srca, srcb;
        logic [2:0] imm, aluc;
        logic       ill, ret;
    } out_t;

    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        logic       rdy;
        out_t       exp;
        bit         chk2;
        out_t       exp2;
    } ent_t;

    logic clk = 1'b0;
    logic r_reset = 1'b1;
    logic [6:0] r_op = '0;
    logic [2:0] r_f3 = '0;
    logic r_f7 = 1'b0, r_zero = 1'b0, r_rdy = 1'b0;

    logic w1_pcw, w1_adr, w1_memw, w1_irw, w1_regw, w1_ill, w1_ret;
    logic [1:0] w1_res, w1_srca, w1_srcb;
    logic [2:0] w1_imm, w1_aluc;
    logic w2_pcw, w2_adr, w2_memw, w2_irw, w2_regw, w2_ill, w2_ret;
    logic [1:0] w2_res, w2_srca, w2_srcb;
    logic [2:0] w2_imm, w2_aluc;
    out_t a1, a2;

    int    n_chk = 0;
    int    n_fail = 0;
    string tname = "";
    ent_t  q[$];
    out_t  obs[$];

    always #5 clk = ~clk;

    ucsbece154a_mc_controller #(.MEM_HANDSHAKE(1'b1), .EXT_BRANCH(1'b1)) dut (
        .clk(clk), .reset(r_reset), .op_i(r_op), .funct3_i(r_f3), .funct7b5_i(r_f7),
        .Zero_i(r_zero), .MemReady_i(r_rdy),
        .PCWrite_o(w1_pcw), .AdrSrc_o(w1_adr), .MemWrite_o(w1_memw), .IRWrite_o(w1_irw),
        .RegWrite_o(w1_regw), .ResultSrc_o(w1_res), .ALUSrcA_o(w1_srca), .ALUSrcB_o(w1_srcb),
        .ImmSrc_o(w1_imm), .ALUControl_o(w1_aluc), .Illegal_o(w1_ill), .Retire_o(w1_ret)
    );

    ucsbece154a_mc_controller #(.MEM_HANDSHAKE(1'b1), .EXT_BRANCH(1'b0)) dut_nobne (
        .clk(clk), .reset(r_reset), .op_i(r_op), .funct3_i(r_f3), .funct7b5_i(r_f7),
        .Zero_i(r_zero), .MemReady_i(r_rdy),
        .PCWrite_o(w2_pcw), .AdrSrc_o(w2_adr), .MemWrite_o(w2_memw), .IRWrite_o(w2_irw),
        .RegWrite_o(w2_regw), .ResultSrc_o(w2_res), .ALUSrcA_o(w2_srca), .ALUSrcB_o(w2_srcb),
        .ImmSrc_o(w2_imm), .ALUControl_o(w2_aluc), .Illegal_o(w2_ill), .Retire_o(w2_ret)
    );

    assign a1 = {w1_pcw, w1_adr, w1_memw, w1_irw, w1_regw, w1_res, w1_srca, w1_srcb,
                 w1_imm, w1_aluc, w1_ill, w1_ret};
    assign a2 = {w2_pcw, w2_adr, w2_memw, w2_irw, w2_regw, w2_res, w2_srca, w2_srcb,
                 w2_imm, w2_aluc, w2_ill, w2_ret};

    // ---------------- model: what each phase of an instruction must show ----
    function automatic logic [2:0] imm_of(input logic [6:0] o);
        if (o == OP_LW || o == OP_I) return 3'b000;
        if (o == OP_SW)  return 3'b001;
        if (o == OP_B)   return 3'b010;
        if (o == OP_JAL) return 3'b011;
        if (o == OP_LUI) return 3'b100;
        return 3'b000;
    endfunction

    function automatic logic [2:0] alu_of(input logic [2:0] f, input logic f7b, input logic op5);
        if (f == 3'b000) return (f7b && op5) ? 3'b001 : 3'b000;
        if (f == 3'b010) return 3'b101;
        if (f == 3'b110) return 3'b011;
        if (f == 3'b111) return 3'b010;
        return 3'b000;
    endfunction

    function automatic out_t m_fetch(input logic [6:0] o, input logic rd);
        out_t t = '0;
        t.imm = imm_of(o); t.srcb = 2'b10; t.res = 2'b10; t.irw = rd; t.pcw = rd;
        return t;
    endfunction
    function automatic out_t m_decode(input logic [6:0] o);
        out_t t = '0;
        t.imm = imm_of(o); t.srca = 2'b01; t.srcb = 2'b01;
        return t;
    endfunction
    function automatic out_t m_memadr(input logic [6:0] o);
        out_t t = '0;
        t.imm = imm_of(o); t.srca = 2'b10; t.srcb = 2'b01;
        return t;
    endfunction
    function automatic out_t m_memread(input logic [6:0] o);
        out_t t = '0;
        t.imm = imm_of(o); t.adr = 1'b1;
        return t;
    endfunction
    function automatic out_t m_memwb(input logic [6:0] o);
        out_t t = '0;
        t.imm = imm_of(o); t.res = 2'b01; t.regw = 1'b1; t.ret = 1'b1;
        return t;
    endfunction
    function automatic out_t m_memwrite(input logic [6:0] o, input logic rd);
        out_t t = '0;
        t.imm = imm_of(o); t.adr = 1'b1; t.memw = 1'b1; t.ret = rd;
        return t;
    endfunction
    function automatic out_t m_exec(input logic [6:0] o, input logic [2:0] f, input logic f7b);
        out_t t = '0;
        t.imm = imm_of(o); t.srca = 2'b10; t.srcb = (o == OP_R) ? 2'b00 : 2'b01;
        t.aluc = alu_of(f, f7b, o[5]);
        return t;
    endfunction
    function automatic out_t m_aluwb(input logic [6:0] o);
        out_t t = '0;
        t.imm = imm_of(o); t.regw = 1'b1; t.ret = 1'b1;
        return t;
    endfunction
    function automatic out_t m_branch(input logic [6:0] o, input logic z, input logic bne);
        out_t t = '0;
        t.imm = imm_of(o); t.srca = 2'b10; t.aluc = 3'b001; t.pcw = z ^ bne; t.ret = 1'b1;
        return t;
    endfunction
    function automatic out_t m_jal(input logic [6:0] o);
        out_t t = '0;
        t.imm = imm_of(o); t.srca = 2'b01; t.srcb = 2'b10; t.pcw = 1'b1;
        return t;
    endfunction
    function automatic out_t m_lui(input logic [6:0] o);
        out_t t = '0;
        t.imm = imm_of(o); t.res = 2'b11; t.regw = 1'b1; t.ret = 1'b1;
        return t;
    endfunction
    function automatic out_t m_error(input logic [6:0] o);
        out_t t = '0;
        t.imm = imm_of(o); t.ill = 1'b1;
        return t;
    endfunction

    // ---------------- stimulus builders ----------------
    task automatic add(input logic r, input logic [6:0] o, input logic [2:0] f, input logic fb,
                       input logic z, input logic rd, input out_t ex);
        ent_t e;
        e.rst = r; e.op = o; e.f3 = f; e.f7 = fb; e.z = z; e.rdy = rd;
        e.exp = ex; e.chk2 = 1'b0; e.exp2 = '0;
        q.push_back(e);
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expand one instruction into its cycle-by-cycle expectations;
    // fw/mw = number of not-ready cycles in FETCH / in the memory state.
    task automatic instr(input logic [6:0] o, input logic [2:0] f, input logic fb,
                         input logic z, input int fw, input int mw);
        for (int i = 0; i < fw; i++) add(0, o, f, fb, z, 1'b0, m_fetch(o, 1'b0));
        add(0, o, f, fb, z, 1'b1, m_fetch(o, 1'b1));
        add(0, o, f, fb, z, rnd(), m_decode(o));
        if (o == OP_LW) begin
            add(0, o, f, fb, z, rnd(), m_memadr(o));
            for (int i = 0; i < mw; i++) add(0, o, f, fb, z, 1'b0, m_memread(o));
            add(0, o, f, fb, z, 1'b1, m_memread(o));
            add(0, o, f, fb, z, rnd(), m_memwb(o));
        end else if (o == OP_SW) begin
            add(0, o, f, fb, z, rnd(), m_memadr(o));
            for (int i = 0; i < mw; i++) add(0, o, f, fb, z, 1'b0, m_memwrite(o, 1'b0));
            add(0, o, f, fb, z, 1'b1, m_memwrite(o, 1'b1));
        end else if (o == OP_R || o == OP_I) begin
            add(0, o, f, fb, z, rnd(), m_exec(o, f, fb));
            add(0, o, f, fb, z, rnd(), m_aluwb(o));
        end else if (o == OP_B) begin
            add(0, o, f, fb, z, rnd(), m_branch(o, z, f == 3'b001));
        end else if (o == OP_JAL) begin
            add(0, o, f, fb, z, rnd(), m_jal(o));
            add(0, o, f, fb, z, rnd(), m_aluwb(o));
        end else if (o == OP_LUI) begin
            add(0, o, f, fb, z, rnd(), m_lui(o));
        end else begin
            add(0, o, f, fb, z, rnd(), m_error(o));
        end
    endtask

    // Reset cycle (ready driven high to show it is ignored), then one idle cycle
    task automatic do_reset(input logic [6:0] o);
        add(1, o, 3'b000, 1'b0, 1'b0, 1'b1, m_fetch(o, 1'b0));
        add(0, o, 3'b000, 1'b0, 1'b0, 1'b0, m_fetch(o, 1'b0));
    endtask

    task automatic mark2(input int lo, input int hi, input out_t ex);
        ent_t e;
        for (int i = lo; i <= hi; i++) begin
            e = q[i]; e.chk2 = 1'b1; e.exp2 = ex; q[i] = e;
        end
    endtask

    // ---------------- compare process ----------------
    task automatic run_q();
        ent_t e;
        int   idx;
        obs.delete();
        idx = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(posedge clk);
            #1;
            r_reset = e.rst; r_op = e.op; r_f3 = e.f3; r_f7 = e.f7; r_zero = e.z; r_rdy = e.rdy;
            @(negedge clk);
            n_chk++;
            if (a1 !== e.exp) begin
                n_fail++;
                $display("FAIL %s cycle %0d: outputs %b, required %b", tname, idx, a1, e.exp);
            end
            if (e.chk2) begin
                n_chk++;
                if (a2 !== e.exp2) begin
                    n_fail++;
                    $display("FAIL %s cycle %0d (no-bne dut): outputs %b, required %b",
                             tname, idx, a2, e.exp2);
                end
            end
            obs.push_back(a1);
            idx++;
        end
    endtask

    task automatic lit(input string nm, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s/%s: got %0d, required %0d", tname, nm, got, want);
        end
    endtask

    // sel: 0 pcw, 1 irw, 2 memw, 3 regw, 4 retire, 5 any enable
    function automatic int ones(input int sel, input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi && i < obs.size(); i++) begin
            case (sel)
                0: n += int'(obs[i].pcw);
                1: n += int'(obs[i].irw);
                2: n += int'(obs[i].memw);
                3: n += int'(obs[i].regw);
                4: n += int'(obs[i].ret);
                default: n += int'(obs[i].pcw | obs[i].irw | obs[i].regw | obs[i].memw);
            endcase
        end
        return n;
    endfunction

    initial begin
        // Reset then lw with ready high throughout
        tname = "reset_lw";
        do_reset(OP_LW);
        instr(OP_LW, 3'b010, 1'b0, 1'b0, 0, 0);
        run_q();
        lit("reset_vector", int'(obs[0]), int'(19'b00000_10_00_10_000_000_0_0));
        lit("cycles", obs.size(), 7);
        lit("irwrite_count", ones(1, 2, 6), 1);
        lit("irwrite_cycle0", int'(obs[2].irw), 1);
        lit("memwb_regwrite", int'(obs[6].regw), 1);
        lit("memwb_resultsrc", int'(obs[6].res), 1);
        lit("retire_count", ones(4, 0, 6), 1);

        // sw with three not-ready cycles in MEMWRITE
        tname = "sw_wait";
        instr(OP_SW, 3'b010, 1'b0, 1'b0, 0, 3);
        run_q();
        lit("cycles", obs.size(), 7);
        lit("memwrite_count", ones(2, 0, 6), 4);
        lit("retire_count", ones(4, 0, 6), 1);
        lit("retire_on_ready", int'(obs[6].ret), 1);

        // FETCH stalled two cycles, then R-type sub
        tname = "fetch_wait_sub";
        instr(OP_R, 3'b000, 1'b1, 1'b0, 2, 0);
        run_q();
        lit("pcwrite_stalled", int'(obs[1].pcw), 0);
        lit("irwrite_cycle2", int'(obs[2].irw), 1);
        lit("irwrite_count", ones(1, 0, 5), 1);
        lit("pcwrite_count", ones(0, 0, 5), 1);
        lit("sub_aluctrl", int'(obs[4].aluc), 1);

        // addi with funct7b5 set must still add
        tname = "addi_f7";
        instr(OP_I, 3'b000, 1'b1, 1'b0, 0, 0);
        run_q();
        lit("addi_aluctrl", int'(obs[2].aluc), 0);

        // or / and / slt
        tname = "r_logic";
        instr(OP_R, 3'b110, 1'b0, 1'b0, 0, 0);
        instr(OP_R, 3'b111, 1'b0, 1'b1, 0, 0);
        instr(OP_R, 3'b010, 1'b0, 1'b0, 0, 0);
        run_q();
        lit("or_aluctrl", int'(obs[2].aluc), 3);
        lit("and_aluctrl", int'(obs[6].aluc), 2);
        lit("slt_aluctrl", int'(obs[10].aluc), 5);

        // Branches; the no-bne instance must trap on the first bne
        tname = "branch";
        instr(OP_B, 3'b000, 1'b0, 1'b1, 0, 0);
        instr(OP_B, 3'b001, 1'b0, 1'b1, 0, 0);
        instr(OP_B, 3'b001, 1'b0, 1'b0, 0, 0);
        mark2(5, 8, m_error(OP_B));
        run_q();
        lit("beq_z1_pcwrite", int'(obs[2].pcw), 1);
        lit("bne_z1_pcwrite", int'(obs[5].pcw), 0);
        lit("bne_z0_pcwrite", int'(obs[8].pcw), 1);
        lit("nobne_illegal", int'(a2.ill), 1);

        // Unknown opcode: ERROR for ten cycles, then reset recovers
        tname = "illegal_op";
        instr(7'h00, 3'b000, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 9; i++) add(0, 7'h00, 3'b000, 1'b0, 1'b0, rnd(), m_error(7'h00));
        do_reset(7'h00);
        mark2(12, 13, m_fetch(7'h00, 1'b0));
        instr(OP_LUI, 3'b000, 1'b0, 1'b0, 0, 0);
        run_q();
        lit("illegal_first", int'(obs[2].ill), 1);
        lit("illegal_tenth", int'(obs[11].ill), 1);
        lit("error_enables", ones(5, 2, 11), 0);
        lit("illegal_in_reset", int'(obs[12].ill), 0);
        lit("illegal_after_reset", int'(obs[13].ill), 0);

        // jal then lui
        tname = "jal_lui";
        instr(OP_JAL, 3'b000, 1'b0, 1'b0, 0, 0);
        instr(OP_LUI, 3'b000, 1'b0, 1'b0, 0, 0);
        run_q();
        lit("jal_pcwrite", int'(obs[2].pcw), 1);
        lit("jal_wb_regwrite", int'(obs[3].regw), 1);
        lit("jal_wb_resultsrc", int'(obs[3].res), 0);
        lit("lui_resultsrc", int'(obs[6].res), 3);
        lit("lui_immsrc", int'(obs[6].imm), 4);

        // Reset while a store is waiting in MEMWRITE
        tname = "abort";
        add(0, OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, m_fetch(OP_SW, 1'b1));
        add(0, OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, m_decode(OP_SW));
        add(0, OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, m_memadr(OP_SW));
        add(0, OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, m_memwrite(OP_SW, 1'b0));
        do_reset(OP_SW);
        instr(OP_R, 3'b000, 1'b0, 1'b0, 0, 0);
        run_q();
        lit("memwrite_before", int'(obs[3].memw), 1);
        lit("memwrite_in_reset", int'(obs[4].memw), 0);
        lit("retire_in_reset", int'(obs[4].ret), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
